// File: rtl/vedic_dot8_accum.sv
// vedic_dot8_accum: pipelined unsigned 8x8 dot-product engine built on a
// combinational Urdhva-Tiryagbhyam (Vedic) multiplier.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand pair handshake
//   in_a, in_b            unsigned 8-bit operands
//   out_valid/out_ready   result handshake
//   out_sum               ACC_W-bit accumulated dot product
//   out_ovf               sticky overflow flag for the current result
//
// Parameters: LEN (pairs per result, 1..255), ACC_W (16..32).
// Optional build macro VEDIC_DOT_SAT_EN: saturate the accumulator to all
// ones on carry-out instead of wrapping modulo 2^ACC_W.
//
// Also contains the multiplier hierarchy: vedic_2x2, vedic_4x4,
// vedicmult_8bit.

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;

    always_comb begin
        p[0] = a[0] & b[0];
        p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c1   = (a[1] & b[0]) & (a[0] & b[1]);
        p[2] = (a[1] & b[1]) ^ c1;
        p[3] = (a[1] & b[1]) & c1;
    end
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [4:0] mid;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    // Crosswise terms are summed first, then placed between the
    // vertical low and high partial products.
    always_comb begin
        mid = {1'b0, q1} + {1'b0, q2};
        p   = 8'(q0) + (8'(mid) << 2) + (8'(q3) << 4);
    end
endmodule

module vedicmult_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] m0;
    logic [7:0] m1;
    logic [7:0] m2;
    logic [7:0] m3;
    logic [8:0] mid;

    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(m0));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(m1));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(m2));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(m3));

    always_comb begin
        mid = {1'b0, m1} + {1'b0, m2};
        p   = 16'(m0) + (16'(mid) << 4) + (16'(m3) << 8);
    end
endmodule

module vedic_dot8_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam logic [7:0] LEN_C = 8'(LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             s1_v_q;
    logic             s1_v_d;
    logic [7:0]       s1_a_q;
    logic [7:0]       s1_a_d;
    logic [7:0]       s1_b_q;
    logic [7:0]       s1_b_d;
    logic             s2_v_q;
    logic             s2_v_d;
    logic [15:0]      s2_p_q;
    logic [15:0]      s2_p_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [15:0]      prod;
    logic [ACC_W:0]   sum_ext;
    logic             accept;
    logic             drain;

    vedicmult_8bit u_mult (.a(s1_a_q), .b(s1_b_q), .p(prod));

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            ACCUM:   in_ready = (cnt_q < LEN_C);
            DONE:    in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
        // Held low combinationally for the whole reset assertion.
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    // Once all pairs are taken and S1 is empty, the last product sits in
    // S2 and lands in the accumulator on the same edge DONE is entered.
    assign drain = (cnt_q == LEN_C) & ~s1_v_q;

    assign sum_ext = {1'b0, acc_q}
                   + {{(ACC_W - 15){1'b0}}, s2_p_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_v_d  = accept;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s2_v_d  = s1_v_q;
        s2_p_d  = s2_p_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (accept) begin
            s1_a_d = in_a;
            s1_b_d = in_b;
            cnt_d  = cnt_q + 8'd1;
        end

        if (s1_v_q) begin
            s2_p_d = prod;
        end

        if (s2_v_q) begin
`ifdef VEDIC_DOT_SAT_EN
            if (sum_ext[ACC_W]) begin
                acc_d = {ACC_W{1'b1}};
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            if (sum_ext[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (drain) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            s1_v_q  <= 1'b0;
            s1_a_q  <= 8'd0;
            s1_b_q  <= 8'd0;
            s2_v_q  <= 1'b0;
            s2_p_q  <= 16'd0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s2_v_q  <= s2_v_d;
            s2_p_q  <= s2_p_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_vedic_dot8_accum.sv
// tb_vedic_dot8_accum: directed and random checks of vedic_dot8_accum
// (LEN=8/ACC_W=24, LEN=8/ACC_W=18, LEN=1/ACC_W=16 instances).

module tb_vedic_dot8_accum;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic        out_ovf;

    logic        in_ready18;
    logic        out_valid18;
    logic [17:0] out_sum18;
    logic        out_ovf18;

    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  in_a1;
    logic [7:0]  in_b1;
    logic        out_valid1;
    logic        out_ready1;
    logic [15:0] out_sum1;
    logic        out_ovf1;

    int errors = 0;
    int checks = 0;

    vedic_dot8_accum #(.LEN(8), .ACC_W(24)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    vedic_dot8_accum #(.LEN(8), .ACC_W(18)) dut18 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready18),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid18), .out_ready(out_ready),
        .out_sum(out_sum18), .out_ovf(out_ovf18)
    );

    vedic_dot8_accum #(.LEN(1), .ACC_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_ovf(out_ovf1)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready=0 after %0d cycles, expected 1", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int lim);
        int t = 0;
        while (!out_valid && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_out: out_valid=0 after %0d cycles, expected 1", lim);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_hs: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        checks++;
        if (out_sum !== 24'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_out: sum=%0d ovf=%b expected 0 0", out_sum, out_ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'd255, 8'd255);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lat0: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lat1: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 24'h07F008 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: valid=%b sum=%0d ovf=%b expected 1 520200 0",
                     out_valid, out_sum, out_ovf);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_one_cycle: valid=%b in_ready=%b expected 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        for (int a = 1; a <= 8; a++) begin
            push(8'(a), 8'd3);
            if (a == 7) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bub_ready7: in_ready=%b expected 1", in_ready);
                end
            end
            if (a < 8) @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bub_ready8: in_ready=%b expected 0", in_ready);
        end
        wait_out(10);
        checks++;
        if (out_sum !== 24'd108 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bub_sum: sum=%0d ovf=%b expected 108 0", out_sum, out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'd255, 8'd255);
        wait_out(10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 24'd520200 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b sum=%0d in_ready=%b expected 1 520200 0",
                         i, out_valid, out_sum, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b in_ready=%b expected 0 1",
                     out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overflow18();
        logic [17:0] exp18;
`ifdef VEDIC_DOT_SAT_EN
        exp18 = 18'd262143;
`else
        exp18 = 18'd258056;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'd255, 8'd255);
        wait_out(10);
        checks++;
        if (out_valid18 !== 1'b1 || out_sum18 !== exp18 || out_ovf18 !== 1'b1) begin
            errors++;
            $display("FAIL ovf18: valid=%b sum=%0d ovf=%b expected 1 %0d 1",
                     out_valid18, out_sum18, out_ovf18, exp18);
        end
        checks++;
        if (out_sum !== 24'd520200 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf24: sum=%0d ovf=%b expected 520200 0", out_sum, out_ovf);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'd1, 8'd1);
        wait_out(10);
        checks++;
        if (out_sum18 !== 18'd8 || out_ovf18 !== 1'b0) begin
            errors++;
            $display("FAIL ovf18_next: sum=%0d ovf=%b expected 8 0", out_sum18, out_ovf18);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'd10, 8'd10);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 24'd0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: valid=%b sum=%0d ovf=%b in_ready=%b expected 0 0 0 0",
                     out_valid, out_sum, out_ovf, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_release: in_ready=%b expected 1", in_ready);
        end
        for (int i = 0; i < 8; i++) push(8'd2, 8'd3);
        wait_out(10);
        checks++;
        if (out_sum !== 24'd48 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_sum: sum=%0d ovf=%b expected 48 0", out_sum, out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_len1();
        out_ready1 = 1'b1;
        in_valid1 = 1'b1;
        in_a1 = 8'd200;
        in_b1 = 8'd100;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL len1_ready: in_ready=%b expected 1", in_ready1);
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL len1_busy: in_ready=%b valid=%b expected 0 0", in_ready1, out_valid1);
        end
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL len1_lat: valid=%b expected 0", out_valid1);
        end
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== 16'd20000 || out_ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL len1_result: valid=%b sum=%0d ovf=%b expected 1 20000 0",
                     out_valid1, out_sum1, out_ovf1);
        end
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL len1_done: valid=%b in_ready=%b expected 0 1", out_valid1, in_ready1);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [23:0] exp;
        out_ready = 1'b1;
        for (int g = 0; g < 25; g++) begin
            exp = 24'd0;
            for (int i = 0; i < 8; i++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                exp = exp + 24'(a) * 24'(b);
                push(a, b);
            end
            wait_out(10);
            checks++;
            if (out_sum !== exp || out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL rand[%0d]: sum=%0d ovf=%b expected %0d 0",
                         g, out_sum, out_ovf, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'd0;
        in_b = 8'd0;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        in_a1 = 8'd0;
        in_b1 = 8'd0;
        out_ready1 = 1'b0;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_stall();
        test_overflow18();
        test_reset_mid();
        test_len1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vedic_dot8_accum.md
Name: vedic_dot8_accum

Overview:
- Pipelined dot-product engine that consumes the product of the combinational vedicmult_8bit multiplier.
- Takes a stream of unsigned 8-bit operand pairs and registers them ahead of the multiplier.
- Registers each 16-bit product and accumulates exactly LEN products into an ACC_W-bit sum.
- Presents the sum on a valid/ready output port; sits directly downstream of the multiplier in the Vedic datapath.

Parameters:
- LEN, 8: number of operand pairs per dot product; legal range 1..255.
- ACC_W, 24: accumulator and result width; legal range 16..32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  8  unsigned operand A.
- in_b  in  8  unsigned operand B.
- out_valid  out  1  out_sum / out_ovf hold a completed result.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated dot product.
- out_ovf  out  1  sticky overflow flag for the current result.

Behaviour:
- Reset: asynchronous, active-high. Asserting rst clears all state immediately and aborts any partial accumulation.
  - Values during/after reset: in_ready=0 while rst is high, 1 in the first cycle after release; out_valid=0, out_sum=0, out_ovf=0.
  - Internal state after reset: pipeline valids=0, count=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: in_ready=1. First accepted pair -> ACCUM.
  - ACCUM: in_ready=1 while accepted count < LEN. Once count reaches LEN, in_ready=0; wait for the pipeline to drain, then -> DONE.
  - DONE: out_valid=1, in_ready=0, out_sum/out_ovf held stable. out_valid && out_ready -> IDLE, with accumulator, out_ovf and count cleared on that edge.
  - LEN=1: IDLE -> DONE path via ACCUM with a single pair.
- Accept rule: a pair is accepted on an edge where in_valid && in_ready. in_valid may drop at any time (bubbles); bubbles insert no accumulation.
- Pipeline (3 cycles):
  - S1: registers in_a, in_b and a valid bit.
  - S2: feeds the S1 registers to vedicmult_8bit and registers the 16-bit product plus a valid bit.
  - S3: when S2 valid, acc <= acc + zero-extended product.
- Latency: if the last pair is accepted on edge k, acc holds the final sum after edge k+2 and out_valid=1 from edge k+2.
- out_sum equals acc; it is visible only with out_valid=1 and is otherwise don't-care (implemented as acc).
- Overflow: carry out of bit ACC_W-1 on any S3 add sets out_ovf. The flag stays set until the result is consumed or rst is asserted. Without saturation the sum wraps modulo 2^ACC_W.
- Output handshake: out_valid, once high, stays high and out_sum is unchanged until out_ready is sampled high. No new pair is accepted in the same cycle as that handshake; in_ready rises the cycle after.
- A handshake attempted with out_ready high while out_valid is low has no effect.

Optional Feature:
- Macro: VEDIC_DOT_SAT_EN.
- Defined: when an add would carry out, acc saturates to all ones (2^ACC_W-1) and holds there for the remaining adds; out_ovf is still set.
- Undefined: modulo wrap as above. Port list and timing are identical in both builds.

Test Plan:
1. LEN=8, ACC_W=24, eight back-to-back pairs (255,255), out_ready=1 -> out_sum=0x07F008 (520200), out_ovf=0; out_valid rises 2 edges after the last accept and lasts one cycle.
2. LEN=8, pairs a=1..8 with b=3, in_valid toggling every other cycle -> out_sum=108; no extra accumulation during bubbles; in_ready drops after the 8th accept.
3. Scenario 1 with out_ready held low for 10 cycles -> out_valid and out_sum=520200 stable throughout, in_ready=0; one-cycle out_ready pulse -> out_valid=0 next cycle, in_ready=1.
4. ACC_W=18, eight pairs (255,255) -> without macro out_sum=258056, out_ovf=1; with VEDIC_DOT_SAT_EN out_sum=262143, out_ovf=1; next result starts with out_ovf=0.
5. rst pulsed asynchronously (mid-cycle) after 5 accepted pairs -> outputs zero immediately; a following 8 pairs of (2,3) yield out_sum=48, with no residue from before the reset.
6. 200 random (a,b) vectors, LEN=8 -> every out_sum equals the sum of the eight a*b values, compared against a bench reference model.
